// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period helpers,
// usable by both the receiver and a matching transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    READY     = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_e;

  // Bit period in clock cycles, truncated.
  function automatic int bit_period(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Counter width able to hold a full bit period.
  function automatic int count_width(input int period);
    return $clog2(period) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side handshake: serial line and go in, byte and data_ready out.
interface uart_rx_if;
  logic       rx;
  logic       go;
  logic [7:0] data;
  logic       data_ready;

  modport master (output rx, output go, input data, input data_ready);
  modport slave  (input rx, input go, output data, output data_ready);
endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle-high level so a reset never looks like a start bit.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples each bit at its middle using a down-counter
// that is loaded with half a period on the start edge and a full period
// after that. The finished byte is held with data_ready until go drops.
//
// state     | meaning
// IDLE      | waiting for go=1 and a low line
// START     | timing to mid start bit, rejects glitches
// DATA      | sampling 8 data bits, LSB first
// STOP      | checking the stop bit at its middle
// READY     | byte valid, held until go=0
// WAIT_HIGH | framing error, waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockFrequencyHz = 20_250_000,
  parameter int BaudRate         = 9600
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int P  = bit_period(ClockFrequencyHz, BaudRate);
  localparam int CW = count_width(P);
  localparam logic [CW-1:0] RELOAD_BIT  = CW'(P);
  localparam logic [CW-1:0] RELOAD_HALF = CW'(P / 2);

  uart_state_e   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    data_r;
  logic          ready_r;
  logic          rs;
  logic          expired;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rs)
  );

  // The counter is loaded so that its terminal count (1) lands exactly on
  // the sampling cycle; <= guards against ever underflowing.
  assign expired = (cnt <= CW'(1));

  // Receive FSM with registered byte and data_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      data_r  <= '0;
      ready_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.go && !rs) begin
            cnt   <= RELOAD_HALF;
            state <= START;
          end
        end
        START: begin
          if (!bus.go) begin
            state <= IDLE;
          end else if (expired) begin
            if (!rs) begin
              cnt     <= RELOAD_BIT;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (!bus.go) begin
            state <= IDLE;
          end else if (expired) begin
            data_r[bit_idx] <= rs;
            cnt             <= RELOAD_BIT;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP: begin
          if (!bus.go) begin
            state <= IDLE;
          end else if (expired) begin
            if (rs) begin
              ready_r <= 1'b1;
              state   <= READY;
            end else begin
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        READY: begin
          if (!bus.go) begin
            ready_r <= 1'b0;
            state   <= IDLE;
          end
        end
        WAIT_HIGH: begin
          if (rs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data       = data_r;
  assign bus.data_ready = ready_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at P=10: table of frames plus hand-written
// glitch, abort and mid-frame reset sequences.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int P = 10;
  // rx change -> two synchronizer edges -> Idle sees rs low on the third
  // edge, then P/2 + 9*P more edges to data_ready.
  localparam int EXP_LAT = 3 + P / 2 + 9 * P;

  typedef struct {
    logic [7:0] byte_val;
    logic       stop_val;
    logic       ack_now;
    logic       exp_ready;
    logic [7:0] exp_data;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[8];

  uart_rx_if bus ();

  uart_rx #(
    .ClockFrequencyHz (10),
    .BaudRate         (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one full frame starting at a negedge; each bit lasts P cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    bus.rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (P) @(negedge clk);
    end
    bus.rx = stop_val;
    repeat (P) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  // Bounded wait for data_ready, counting rising edges from the call.
  task automatic watch(output logic seen, output int lat, output logic [7:0] dat);
    seen = 1'b0;
    lat  = 0;
    dat  = '0;
    for (int i = 1; i <= 110; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.data_ready) begin
        seen = 1'b1;
        lat  = i;
        dat  = bus.data;
        break;
      end
    end
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    logic       seen;
    int         lat;
    logic [7:0] dat;
    logic       ack_ready;
    ack_ready = 1'b1;
    fork
      send_frame(v.byte_val, v.stop_val);
      begin
        watch(seen, lat, dat);
        if (v.ack_now && seen) begin
          bus.go = 1'b0;
          @(negedge clk);
          ack_ready = bus.data_ready;
          bus.go = 1'b1;
        end
      end
    join
    check({tag, "_seen"}, 32'(seen), 32'(v.exp_ready));
    if (v.exp_ready) begin
      check({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
      check({tag, "_data"}, 32'(dat), 32'(v.exp_data));
      if (v.ack_now) begin
        check({tag, "_ack_clear"}, 32'(ack_ready), 32'd0);
      end else begin
        repeat (25) @(negedge clk);
        check({tag, "_hold_ready"}, 32'(bus.data_ready), 32'd1);
        check({tag, "_hold_data"}, 32'(bus.data), 32'(v.exp_data));
        bus.go = 1'b0;
        @(negedge clk);
        check({tag, "_ack_clear"}, 32'(bus.data_ready), 32'd0);
        bus.go = 1'b1;
        @(negedge clk);
      end
    end else begin
      repeat (10) @(negedge clk);
      check({tag, "_no_ready"}, 32'(bus.data_ready), 32'd0);
      check({tag, "_idle"}, 32'(dut.state), 32'(IDLE));
      if (seen) begin
        bus.go = 1'b0;
        @(negedge clk);
        bus.go = 1'b1;
      end
    end
  endtask

  initial begin
    logic       seen;
    int         lat;
    logic [7:0] dat;
    vec_t       v;

    checks = 0;
    errors = 0;
    //           byte   stop  ack   ready data
    vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C};
    vecs[3] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{8'h12, 1'b1, 1'b0, 1'b1, 8'h12};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[7] = '{8'h0F, 1'b1, 1'b0, 1'b1, 8'h0F};

    rst    = 1'b1;
    bus.rx = 1'b1;
    bus.go = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(bus.data), 32'h0);
    check("reset_ready", 32'(bus.data_ready), 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vector(vecs[i], $sformatf("vec%0d", i));
    end

    // Short low pulse on the line must be rejected at mid start bit.
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_idle", 32'(dut.state), 32'(IDLE));
    check("glitch_ready", 32'(bus.data_ready), 32'd0);
    v = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81};
    run_vector(v, "after_glitch");

    // go dropped in the middle of data bit 4 aborts the frame.
    fork
      send_frame(8'hF0, 1'b1);
      watch(seen, lat, dat);
      begin
        repeat (P + 4 * P + P / 2) @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'(dut.state), 32'(IDLE));
      end
    join
    check("abort_no_ready", 32'(seen), 32'd0);
    bus.go = 1'b1;
    repeat (5) @(negedge clk);
    v = '{8'h0F, 1'b1, 1'b0, 1'b1, 8'h0F};
    run_vector(v, "after_abort");

    // Reset during data bit 2 of 0xC3: bits 0 and 1 (both 1) already in.
    bus.rx = 1'b0;
    repeat (P) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2 * P) @(negedge clk);
    bus.rx = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_partial", 32'(bus.data[1:0]), 32'h3);
    rst = 1'b1;
    #1;
    check("rst_data", 32'(bus.data), 32'h0);
    check("rst_ready", 32'(bus.data_ready), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    bus.rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    v = '{8'h7E, 1'b1, 1'b0, 1'b1, 8'h7E};
    run_vector(v, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter ClockFrequencyHz, default 20_250_000, system clock frequency in Hz.
REQ-002 Parameter BaudRate, default 9600, line rate; bit period P = ClockFrequencyHz / BaudRate cycles, truncated to an integer, P >= 4.
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst  input  1  one clock; reset is asynchronous and active-high.
REQ-005 rx  input  1  asynchronous serial line, idle high.
REQ-006 go  input  1  high enables receiving; low acknowledges data_ready or aborts a frame.
REQ-007 data  output  8  byte being assembled; complete and stable while data_ready is high.
REQ-008 data_ready  output  1  high when a full, valid byte is in data.

Function
REQ-009 Frame format SHALL be 8N1: one low start bit, 8 data bits LSB first, one high stop bit, no parity.
REQ-010 rx SHALL pass through a two-flop synchronizer; all decisions use the synchronized value rs.
REQ-011 States: Idle, Start, Data, Stop, Ready, WaitHigh.
REQ-012 Idle: when go=1 and rs=0, SHALL load counter with P/2 and enter Start; when go=0, SHALL stay in Idle.
REQ-013 Start: at counter expiry (mid start bit), rs=0 -> reload P, bit index 0, enter Data; rs=1 -> glitch, return to Idle with no output change.
REQ-014 Data: at each counter expiry SHALL shift rs into data at the current bit index (bit 0 first), reload P; after bit 7 SHALL reload P and enter Stop.
REQ-015 Stop: at counter expiry, rs=1 -> set data_ready=1, enter Ready; rs=0 -> framing error, discard byte, data_ready stays 0, enter WaitHigh.
REQ-016 WaitHigh: SHALL remain until rs=1, then enter Idle.
REQ-017 Ready: data and data_ready=1 SHALL hold indefinitely while go=1; later rx activity is ignored and overrun data is lost.
REQ-018 Ready with go=0: SHALL clear data_ready on the next edge and enter Idle; reception resumes once go returns high.
REQ-019 go=0 in Start, Data or Stop SHALL abort the frame and enter Idle next cycle; data_ready stays 0.
REQ-020 data_ready SHALL rise exactly P/2 + 9*P clock cycles after the cycle rs is first sampled low in Idle, i.e. at mid stop bit, leaving half a bit period to acknowledge before the next start bit.
REQ-021 data MAY change during reception; only its value while data_ready=1 is defined.
REQ-022 Counters SHALL be sized $clog2(P)+1 bits; no wrap-around beyond reload values.

Reset
REQ-023 rst high SHALL immediately force state Idle, data=0, data_ready=0, counter=0, bit index=0, synchronizer flops=1.
REQ-024 rst asserted mid-frame SHALL discard the partial byte; after release the receiver waits for the next falling edge with go=1.

Structure
REQ-025 State enumeration SHALL live in a shared package uart_pkg, reusable by the transmitter.
REQ-026 Single module; no sub-module except an optional inline two-flop synchronizer named sync2.

Verification
REQ-027 P=10 (ClockFrequencyHz=10, BaudRate=1), go=1, send 0x55 -> data_ready rises 95 cycles after rs falls, data=0x55, held until go=0.
REQ-028 Send 0xA5, pulse go low 1 cycle on data_ready, then immediately send 0x3C -> second data_ready with data=0x3C, no byte lost.
REQ-029 rx low for 3 cycles then high -> no data_ready, state back to Idle, next frame 0x81 received correctly.
REQ-030 Frame 0xFF with stop bit driven low -> no data_ready; after rx returns high, frame 0x12 received as 0x12.
REQ-031 go driven low during data bit 4 of 0xF0 -> no data_ready; go high, next frame 0x0F received as 0x0F.
REQ-032 rst pulsed during data bit 2 -> data=0, data_ready=0 immediately; subsequent frame 0x7E received correctly.
